// File: rtl/wb_dbg_pkg.sv
// Shared types and constants for the Wishbone debug master.
package wb_dbg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // RspBusErr is reserved until the bus gains an err_i line.
    typedef enum logic [1:0] {
        RspOk      = 2'd0,
        RspTimeout = 2'd1,
        RspBusErr  = 2'd2
    } rsp_code_e;

    function automatic logic [31:0] rsp_data(input logic we, input logic [31:0] dat);
        return we ? 32'h0 : dat;
    endfunction

endpackage

// File: rtl/wb_dbg_master_if.sv
// Command, response and Wishbone signals of the debug master, bundled as one interface.
interface wb_dbg_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_dbg_timeout.sv
// Bus-cycle timeout counter: clear, count enable, terminal count at TIMEOUT-1.
module wb_dbg_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TO_W-1:0] TermCnt = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TermCnt);

endmodule

// File: rtl/wb_dbg_master.sv
// Single-transfer Wishbone classic initiator: one command in, one bus cycle, one response out.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_dbg_master_if.master bus,
    output logic            busy
);

    state_e      r_state, w_state_d;
    logic        r_cyc, w_cyc_d;
    logic        r_we, w_we_d;
    logic [3:0]  r_sel, w_sel_d;
    logic [31:0] r_adr, w_adr_d;
    logic [31:0] r_dat, w_dat_d;
    logic        r_rsp_valid, w_rsp_valid_d;
    logic [31:0] r_rsp_dat, w_rsp_dat_d;
    rsp_code_e   r_rsp_code, w_rsp_code_d;
    logic        w_to_clr;
    logic        w_to_en;
    logic        w_to_tc;

    wb_dbg_timeout #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_timeout (
        .i_clk(wb_clk_i),
        .i_rst(wb_rst_i),
        .i_clr(w_to_clr),
        .i_en (w_to_en),
        .o_tc (w_to_tc)
    );

    always_comb begin
        w_state_d     = r_state;
        w_cyc_d       = r_cyc;
        w_we_d        = r_we;
        w_sel_d       = r_sel;
        w_adr_d       = r_adr;
        w_dat_d       = r_dat;
        w_rsp_valid_d = r_rsp_valid;
        w_rsp_dat_d   = r_rsp_dat;
        w_rsp_code_d  = r_rsp_code;
        w_to_clr      = 1'b0;
        w_to_en       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    w_we_d    = bus.cmd_we;
                    w_sel_d   = bus.cmd_sel;
                    w_adr_d   = bus.cmd_adr;
                    w_dat_d   = bus.cmd_dat;
                    w_cyc_d   = 1'b1;
                    w_to_clr  = 1'b1;
                    w_state_d = StBus;
                end
            end
            StBus: begin
                // Ack is checked first so an ack on the terminal-count edge completes normally.
                if (bus.wbm_ack_i) begin
                    w_rsp_dat_d   = rsp_data(r_we, bus.wbm_dat_i);
                    w_rsp_code_d  = RspOk;
                    w_cyc_d       = 1'b0;
                    w_we_d        = 1'b0;
                    w_rsp_valid_d = 1'b1;
                    w_state_d     = StResp;
                end else if (w_to_tc) begin
                    w_rsp_dat_d   = 32'h0;
                    w_rsp_code_d  = RspTimeout;
                    w_cyc_d       = 1'b0;
                    w_we_d        = 1'b0;
                    w_rsp_valid_d = 1'b1;
                    w_state_d     = StResp;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_state_d     = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= StIdle;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'h0;
            r_adr       <= 32'h0;
            r_dat       <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'h0;
            r_rsp_code  <= RspOk;
        end else begin
            r_state     <= w_state_d;
            r_cyc       <= w_cyc_d;
            r_we        <= w_we_d;
            r_sel       <= w_sel_d;
            r_adr       <= w_adr_d;
            r_dat       <= w_dat_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_dat   <= w_rsp_dat_d;
            r_rsp_code  <= w_rsp_code_d;
        end
    end

    // Classic single transfers: strobe always tracks cycle.
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_we_o  = r_we;
    assign bus.wbm_sel_o = r_sel;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_dat;
    assign bus.cmd_ready = (r_state == StIdle);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_dat   = r_rsp_dat;
    assign bus.rsp_err   = (r_rsp_code != RspOk);
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_wb_dbg_master.sv
// Self-checking bench: vector table, hand sequences for corner cases, random traffic vs. a memory model.
module tb_wb_dbg_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_dbg_master_if bus8 ();
    wb_dbg_master_if bus4 ();
    logic busy8, busy4;

    wb_dbg_master #(.TIMEOUT(8), .TO_W(16)) u_dut8 (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus8),
        .busy    (busy8)
    );

    wb_dbg_master #(.TIMEOUT(4), .TO_W(16)) u_dut4 (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus4),
        .busy    (busy4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Slave with registers at 0x8 / 0xC and a registered one-cycle ack; other addresses never ack.
    logic [31:0] sl_reg8 = 32'h0;
    logic [31:0] sl_regc = 32'hFFFF_FFFF;
    logic [31:0] sl_dat;
    logic        sl_ack;
    logic        inj_ack;
    assign bus8.wbm_ack_i = sl_ack | inj_ack;
    assign bus8.wbm_dat_i = sl_dat;
    assign bus4.wbm_dat_i = 32'hC0FF_EE11;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_ack <= 1'b0;
            sl_dat <= 32'h0;
        end else begin
            sl_ack <= 1'b0;
            if (bus8.wbm_cyc_o && bus8.wbm_stb_o && !sl_ack &&
                (bus8.wbm_adr_o == 32'h8 || bus8.wbm_adr_o == 32'hC)) begin
                sl_ack <= 1'b1;
                if (bus8.wbm_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus8.wbm_sel_o[b]) begin
                            if (bus8.wbm_adr_o == 32'h8) sl_reg8[8*b+:8] <= bus8.wbm_dat_o[8*b+:8];
                            else sl_regc[8*b+:8] <= bus8.wbm_dat_o[8*b+:8];
                        end
                    end
                end else begin
                    sl_dat <= (bus8.wbm_adr_o == 32'h8) ? sl_reg8 : sl_regc;
                end
            end
        end
    end

    // Reference: what each register should hold, by byte-enable merge.
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b+:8] = new_v[8*b+:8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int rdy_delay, input bit late_ack,
                           output logic [31:0] o_dat, output logic o_err, output int o_cyc,
                           output bit o_hold_ok, output bit o_done);
        int guard;
        o_dat = 32'h0; o_err = 1'b0; o_cyc = 0; o_hold_ok = 1'b1; o_done = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!bus8.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus8.cmd_ready) begin
            check("cmd_ready_wait", 32'(bus8.cmd_ready), 32'h1);
            return;
        end
        bus8.cmd_we = we; bus8.cmd_adr = adr; bus8.cmd_dat = dat; bus8.cmd_sel = sel;
        bus8.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus8.cmd_valid = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!bus8.rsp_valid && guard < 100) begin
            if (bus8.wbm_cyc_o && bus8.wbm_stb_o) begin
                o_cyc++;
                if (bus8.wbm_adr_o !== adr || bus8.wbm_we_o !== we || bus8.wbm_sel_o !== sel ||
                    bus8.wbm_dat_o !== dat) o_hold_ok = 1'b0;
            end else if (bus8.wbm_cyc_o || bus8.wbm_stb_o) begin
                o_hold_ok = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        if (!bus8.rsp_valid) begin
            check("rsp_valid_wait", 32'(bus8.rsp_valid), 32'h1);
            return;
        end
        o_dat = bus8.rsp_dat;
        o_err = bus8.rsp_err;
        for (int i = 0; i < rdy_delay; i++) begin
            if (late_ack && i == 1) inj_ack = 1'b1;
            @(negedge clk);
            inj_ack = 1'b0;
            if (!bus8.rsp_valid || bus8.rsp_dat !== o_dat || bus8.rsp_err !== o_err ||
                bus8.cmd_ready || bus8.wbm_cyc_o || bus8.wbm_stb_o) o_hold_ok = 1'b0;
        end
        bus8.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus8.rsp_ready = 1'b0;
        @(negedge clk);
        if (bus8.rsp_valid || !bus8.cmd_ready || busy8) o_hold_ok = 1'b0;
        o_done = 1'b1;
    endtask

    task automatic run_and_check(input string name, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel, input int dly,
                                 input bit late, input logic [31:0] exp_dat, input logic exp_err,
                                 input int exp_cyc);
        logic [31:0] a_dat;
        logic        a_err;
        int          a_cyc;
        bit          hold_ok, done;
        do_xfer(we, adr, dat, sel, dly, late, a_dat, a_err, a_cyc, hold_ok, done);
        if (done) begin
            check({name, ".rsp_dat"}, a_dat, exp_dat);
            check({name, ".rsp_err"}, 32'(a_err), 32'(exp_err));
            check({name, ".cyc_cycles"}, 32'(a_cyc), 32'(exp_cyc));
            check({name, ".stable"}, 32'(hold_ok), 32'h1);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          dly;
        bit          late;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] adr, dat, exp_dat;
        logic [3:0]  sel;
        logic        we, exp_err;
        int          exp_cyc;

        vecs[0] = '{"wr8",     1'b1, 32'h8, 32'hA5A5_1234, 4'hF, 0,  1'b0, 32'h0,         1'b0, 2};
        vecs[1] = '{"rd8",     1'b0, 32'h8, 32'h0,         4'hF, 0,  1'b0, 32'hA5A5_1234, 1'b0, 2};
        vecs[2] = '{"wrc_prt", 1'b1, 32'hC, 32'h0,         4'h5, 1,  1'b0, 32'h0,         1'b0, 2};
        vecs[3] = '{"rdc",     1'b0, 32'hC, 32'h0,         4'hF, 0,  1'b0, 32'hFF00_FF00, 1'b0, 2};
        vecs[4] = '{"tmo_rd0", 1'b0, 32'h0, 32'h0,         4'hF, 5,  1'b1, 32'h0,         1'b1, 8};
        vecs[5] = '{"bp_rd8",  1'b0, 32'h8, 32'h0,         4'h3, 10, 1'b0, 32'hA5A5_1234, 1'b0, 2};

        ref_mem[32'h8] = 32'h0;
        ref_mem[32'hC] = 32'hFFFF_FFFF;

        bus8.cmd_valid = 1'b0; bus8.cmd_we = 1'b0; bus8.cmd_adr = '0; bus8.cmd_dat = '0;
        bus8.cmd_sel = '0; bus8.rsp_ready = 1'b0; inj_ack = 1'b0;
        bus4.cmd_valid = 1'b0; bus4.cmd_we = 1'b0; bus4.cmd_adr = '0; bus4.cmd_dat = '0;
        bus4.cmd_sel = '0; bus4.rsp_ready = 1'b0; bus4.wbm_ack_i = 1'b0;

        // Reset state, sampled while reset is still asserted.
        #12;
        check("rst.cyc", 32'(bus8.wbm_cyc_o), 32'h0);
        check("rst.rsp_valid", 32'(bus8.rsp_valid), 32'h0);
        check("rst.cmd_ready", 32'(bus8.cmd_ready), 32'h1);
        check("rst.busy", 32'(busy8), 32'h0);
        check("rst.adr", bus8.wbm_adr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_and_check(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                          vecs[i].dly, vecs[i].late, vecs[i].exp_dat, vecs[i].exp_err,
                          vecs[i].exp_cyc);
            if (vecs[i].we && ref_mem.exists(vecs[i].adr))
                ref_mem[vecs[i].adr] = merge(ref_mem[vecs[i].adr], vecs[i].dat, vecs[i].sel);
        end

        // Asynchronous reset in the middle of a bus cycle.
        @(negedge clk);
        bus8.cmd_we = 1'b0; bus8.cmd_adr = 32'h8; bus8.cmd_sel = 4'hF; bus8.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus8.cmd_valid = 1'b0;
        check("mid_rst.cyc_before", 32'(bus8.wbm_cyc_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst.cyc", 32'(bus8.wbm_cyc_o), 32'h0);
        check("mid_rst.stb", 32'(bus8.wbm_stb_o), 32'h0);
        check("mid_rst.rsp_valid", 32'(bus8.rsp_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.cmd_ready", 32'(bus8.cmd_ready), 32'h1);
        check("post_rst.busy", 32'(busy8), 32'h0);
        run_and_check("post_rst_rd8", 1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, ref_mem[32'h8], 1'b0, 2);

        // Ack arriving on the same edge the TIMEOUT=4 instance would abort.
        @(negedge clk);
        bus4.cmd_we = 1'b0; bus4.cmd_adr = 32'h40; bus4.cmd_sel = 4'hF; bus4.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus4.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("tmo_edge.cyc_4th", 32'(bus4.wbm_cyc_o), 32'h1);
        bus4.wbm_ack_i = 1'b1;
        @(posedge clk);
        #1 bus4.wbm_ack_i = 1'b0;
        @(negedge clk);
        check("tmo_edge.rsp_valid", 32'(bus4.rsp_valid), 32'h1);
        check("tmo_edge.rsp_err", 32'(bus4.rsp_err), 32'h0);
        check("tmo_edge.rsp_dat", bus4.rsp_dat, 32'hC0FF_EE11);
        bus4.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus4.rsp_ready = 1'b0;
        @(negedge clk);
        check("tmo_edge.idle", 32'(busy4), 32'h0);

        // Random traffic against the memory model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       adr = 32'h0;
                1:       adr = 32'h8;
                default: adr = 32'hC;
            endcase
            we  = 1'($urandom_range(0, 1));
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            if (!ref_mem.exists(adr)) begin
                exp_dat = 32'h0; exp_err = 1'b1; exp_cyc = 8;
            end else begin
                exp_dat = we ? 32'h0 : ref_mem[adr]; exp_err = 1'b0; exp_cyc = 2;
                if (we) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
            end
            run_and_check($sformatf("rnd%0d", n), we, adr, dat, sel,
                          int'($urandom_range(0, 3)), 1'b0, exp_dat, exp_err, exp_cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
